// File: rtl/mem_sched_pkg.sv
`default_nettype none
// ============================================================================
// mem_sched_pkg
// Shared types for the vector memory-op issue scheduler: op descriptor,
// addressing-mode encoding, scheduler states and the mode one-hot decode.
// Revision: 1.0
// ============================================================================
package mem_sched_pkg;

    // Addressing mode as carried on the dispatch bus; 2'b00 is illegal
    typedef enum logic [1:0] {
        MODE_UNIT    = 2'b01,
        MODE_STRIDED = 2'b10,
        MODE_IDX     = 2'b11
    } mem_mode_e;

    // One queued vector load/store. mode is kept as raw bits so an
    // illegal encoding can travel through the queue and be flagged at the head.
    typedef struct packed {
        logic        store;
        logic [1:0]  mode;
        logic [2:0]  sew;
        logic [2:0]  lmul;
        logic [2:0]  dw;
        logic [31:0] base;
        logic [31:0] stride;
        logic [31:0] vl;
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_DRAIN = 2'd2
    } sched_state_e;

    // Returns {idx, strided, unit}; the illegal encoding decodes to all zero
    function automatic logic [2:0] mode_onehot(input logic [1:0] mode);
        logic [2:0] oh;
        oh = 3'b000;
        case (mode)
            MODE_UNIT:    oh = 3'b001;
            MODE_STRIDED: oh = 3'b010;
            MODE_IDX:     oh = 3'b100;
            default:      oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_op_fifo.sv
`default_nettype none
// ============================================================================
// mem_op_fifo
// Synchronous show-ahead FIFO of mem_op_t. The head entry is visible on
// `head` whenever the FIFO is non-empty. Caller guarantees no push when
// full and no pop when empty.
// Revision: 1.0
// ============================================================================
module mem_op_fifo
    import mem_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  mem_op_t                  wr_op,
    input  logic                     pop,
    output mem_op_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    mem_op_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Storage array; contents need no reset because count gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_op;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_op_sched.sv
`default_nettype none
// ============================================================================
// mem_op_sched
// In-order issue scheduler for vector loads/stores towards mem_subsys.
// Queues dispatched ops, presents the head op on the mcu config bus with a
// load or store valid, tracks outstanding ops per direction and never lets
// the direction change until the opposite direction has fully drained.
// Revision: 1.0
// ============================================================================
module mem_op_sched
    import mem_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           op_vld_i,
    output logic                           op_rdy_o,
    input  logic                           op_store_i,
    input  logic [1:0]                     op_mode_i,
    input  logic [2:0]                     op_sew_i,
    input  logic [2:0]                     op_lmul_i,
    input  logic [2:0]                     op_data_width_i,
    input  logic [31:0]                    op_base_addr_i,
    input  logic [31:0]                    op_stride_i,
    input  logic [31:0]                    op_vl_i,
    output logic [2:0]                     mcu_sew_o,
    output logic [2:0]                     mcu_lmul_o,
    output logic [2:0]                     mcu_data_width_o,
    output logic [31:0]                    mcu_base_addr_o,
    output logic [31:0]                    mcu_stride_o,
    output logic [31:0]                    mcu_vl_o,
    output logic                           mcu_unit_ld_st_o,
    output logic                           mcu_strided_ld_st_o,
    output logic                           mcu_idx_ld_st_o,
    output logic                           mcu_ld_vld_o,
    input  logic                           mcu_ld_rdy_i,
    output logic                           mcu_st_vld_o,
    input  logic                           mcu_st_rdy_i,
    input  logic                           ld_done_i,
    input  logic                           st_done_i,
    output logic [$clog2(MAX_OUT+1)-1:0]   ld_out_o,
    output logic [$clog2(MAX_OUT+1)-1:0]   st_out_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int QW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] MAX_CNT = MAX_OUT[CW-1:0];
    localparam logic [QW-1:0] ONE_CNT = {{(QW-1){1'b0}}, 1'b1};

    sched_state_e   state;
    mem_op_t        in_op;
    mem_op_t        head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [QW-1:0]  fifo_count;
    logic           push;
    logic           pop;
    logic           ld_hs;
    logic           st_hs;
    logic           head_illegal;
    logic           head_skip;
    logic           head_elig;
    logic           one_left;
    logic           q_nonempty_next;
    logic           ld_dec;
    logic           st_dec;
    logic [CW-1:0]  ld_next;
    logic [CW-1:0]  st_next;

    assign in_op = '{store:  op_store_i,
                     mode:   op_mode_i,
                     sew:    op_sew_i,
                     lmul:   op_lmul_i,
                     dw:     op_data_width_i,
                     base:   op_base_addr_i,
                     stride: op_stride_i,
                     vl:     op_vl_i};

    mem_op_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wr_op (in_op),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign op_rdy_o = !fifo_full;

    // Handshakes, head classification, pop decision and next counter values
    always_comb begin
        push         = op_vld_i && !fifo_full;
        ld_hs        = (state == ST_ISSUE) && mcu_ld_vld_o && mcu_ld_rdy_i;
        st_hs        = (state == ST_ISSUE) && mcu_st_vld_o && mcu_st_rdy_i;
        head_illegal = (head.mode == 2'b00);
        // Zero-length and illegal ops are dropped at the head without issue
        head_skip    = (state != ST_ISSUE) && !fifo_empty &&
                       ((head.vl == '0) || head_illegal);
        // A direction may only issue once the other one has fully drained
        head_elig    = head.store ? ((ld_out_o == '0) && (st_out_o < MAX_CNT))
                                  : ((st_out_o == '0) && (ld_out_o < MAX_CNT));
        pop          = ld_hs || st_hs || head_skip;
        one_left     = (fifo_count == ONE_CNT);
        q_nonempty_next = push || !(fifo_empty || (one_left && pop));

        // A done pulse with nothing outstanding is ignored (and flagged)
        ld_dec  = ld_done_i && (ld_out_o != '0);
        st_dec  = st_done_i && (st_out_o != '0);
        ld_next = ld_out_o;
        st_next = st_out_o;
        if (ld_hs && !ld_dec) begin
            ld_next = ld_out_o + 1'b1;
        end else if (!ld_hs && ld_dec) begin
            ld_next = ld_out_o - 1'b1;
        end
        if (st_hs && !st_dec) begin
            st_next = st_out_o + 1'b1;
        end else if (!st_hs && st_dec) begin
            st_next = st_out_o - 1'b1;
        end
    end

    // Outstanding counters, busy and sticky error flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_out_o <= '0;
            st_out_o <= '0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            ld_out_o <= ld_next;
            st_out_o <= st_next;
            busy_o   <= q_nonempty_next || (ld_next != '0) || (st_next != '0);
            err_o    <= err_o
                        || (ld_done_i && (ld_out_o == '0))
                        || (st_done_i && (st_out_o == '0))
                        || (head_skip && head_illegal);
        end
    end

    // Issue FSM; config bus and valids are registered and zero outside ISSUE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= ST_IDLE;
            mcu_sew_o           <= '0;
            mcu_lmul_o          <= '0;
            mcu_data_width_o    <= '0;
            mcu_base_addr_o     <= '0;
            mcu_stride_o        <= '0;
            mcu_vl_o            <= '0;
            mcu_unit_ld_st_o    <= 1'b0;
            mcu_strided_ld_st_o <= 1'b0;
            mcu_idx_ld_st_o     <= 1'b0;
            mcu_ld_vld_o        <= 1'b0;
            mcu_st_vld_o        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_WAIT_DRAIN: begin
                    if (fifo_empty) begin
                        state <= ST_IDLE;
                    end else if (head_skip) begin
                        state <= (one_left && !push) ? ST_IDLE : ST_WAIT_DRAIN;
                    end else if (head_elig) begin
                        state               <= ST_ISSUE;
                        mcu_sew_o           <= head.sew;
                        mcu_lmul_o          <= head.lmul;
                        mcu_data_width_o    <= head.dw;
                        mcu_base_addr_o     <= head.base;
                        mcu_stride_o        <= head.stride;
                        mcu_vl_o            <= head.vl;
                        {mcu_idx_ld_st_o, mcu_strided_ld_st_o, mcu_unit_ld_st_o}
                                            <= mode_onehot(head.mode);
                        mcu_ld_vld_o        <= !head.store;
                        mcu_st_vld_o        <= head.store;
                    end else begin
                        state <= ST_WAIT_DRAIN;
                    end
                end
                ST_ISSUE: begin
                    // Dropping vld for a cycle lets the counters settle
                    // before the next head is judged
                    if (ld_hs || st_hs) begin
                        state               <= (one_left && !push) ? ST_IDLE : ST_WAIT_DRAIN;
                        mcu_sew_o           <= '0;
                        mcu_lmul_o          <= '0;
                        mcu_data_width_o    <= '0;
                        mcu_base_addr_o     <= '0;
                        mcu_stride_o        <= '0;
                        mcu_vl_o            <= '0;
                        mcu_unit_ld_st_o    <= 1'b0;
                        mcu_strided_ld_st_o <= 1'b0;
                        mcu_idx_ld_st_o     <= 1'b0;
                        mcu_ld_vld_o        <= 1'b0;
                        mcu_st_vld_o        <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_op_sched.sv
`default_nettype none
// ============================================================================
// tb_mem_op_sched
// Directed bench for mem_op_sched with a queue-based reference model and
// literal expectations for the key scenarios.
// Revision: 1.0
// ============================================================================
module tb_mem_op_sched;
    import mem_sched_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        op_vld = 1'b0;
    logic        op_store = 1'b0;
    logic [1:0]  op_mode = 2'b00;
    logic [2:0]  op_sew = 3'b000;
    logic [2:0]  op_lmul = 3'b000;
    logic [2:0]  op_dw = 3'b000;
    logic [31:0] op_base = '0;
    logic [31:0] op_stride = '0;
    logic [31:0] op_vl = '0;
    logic        ld_rdy = 1'b0;
    logic        st_rdy = 1'b0;
    logic        ld_done = 1'b0;
    logic        st_done = 1'b0;

    logic        op_rdy_o;
    logic [2:0]  mcu_sew_o, mcu_lmul_o, mcu_data_width_o;
    logic [31:0] mcu_base_addr_o, mcu_stride_o, mcu_vl_o;
    logic        mcu_unit_ld_st_o, mcu_strided_ld_st_o, mcu_idx_ld_st_o;
    logic        mcu_ld_vld_o, mcu_st_vld_o;
    logic [1:0]  ld_out_o, st_out_o;
    logic        busy_o, err_o;

    mem_op_sched #(
        .FIFO_DEPTH (DEPTH),
        .MAX_OUT    (MAXO)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .op_vld_i            (op_vld),
        .op_rdy_o            (op_rdy_o),
        .op_store_i          (op_store),
        .op_mode_i           (op_mode),
        .op_sew_i            (op_sew),
        .op_lmul_i           (op_lmul),
        .op_data_width_i     (op_dw),
        .op_base_addr_i      (op_base),
        .op_stride_i         (op_stride),
        .op_vl_i             (op_vl),
        .mcu_sew_o           (mcu_sew_o),
        .mcu_lmul_o          (mcu_lmul_o),
        .mcu_data_width_o    (mcu_data_width_o),
        .mcu_base_addr_o     (mcu_base_addr_o),
        .mcu_stride_o        (mcu_stride_o),
        .mcu_vl_o            (mcu_vl_o),
        .mcu_unit_ld_st_o    (mcu_unit_ld_st_o),
        .mcu_strided_ld_st_o (mcu_strided_ld_st_o),
        .mcu_idx_ld_st_o     (mcu_idx_ld_st_o),
        .mcu_ld_vld_o        (mcu_ld_vld_o),
        .mcu_ld_rdy_i        (ld_rdy),
        .mcu_st_vld_o        (mcu_st_vld_o),
        .mcu_st_rdy_i        (st_rdy),
        .ld_done_i           (ld_done),
        .st_done_i           (st_done),
        .ld_out_o            (ld_out_o),
        .st_out_o            (st_out_o),
        .busy_o              (busy_o),
        .err_o               (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending ops in order, per-direction outstanding
    // counts, whether the head is currently offered, and the error flag
    mem_op_t mq[$];
    int      m_ld = 0;
    int      m_st = 0;
    bit      m_pres = 1'b0;
    bit      m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ld = 0;
        m_st = 0;
        m_pres = 1'b0;
        m_err = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge
    task automatic model_step();
        int      ld0;
        int      st0;
        int      qs0;
        int      inc_l;
        int      inc_s;
        int      dec_l;
        int      dec_s;
        bit      popq;
        mem_op_t h;
        mem_op_t n;
        ld0 = m_ld; st0 = m_st; qs0 = mq.size();
        inc_l = 0; inc_s = 0; dec_l = 0; dec_s = 0; popq = 1'b0;
        if (ld_done) begin
            if (ld0 > 0) dec_l = 1; else m_err = 1'b1;
        end
        if (st_done) begin
            if (st0 > 0) dec_s = 1; else m_err = 1'b1;
        end
        if (qs0 > 0) begin
            h = mq[0];
            if (m_pres) begin
                if (h.store ? st_rdy : ld_rdy) begin
                    popq = 1'b1;
                    m_pres = 1'b0;
                    if (h.store) inc_s = 1; else inc_l = 1;
                end
            end else if (h.vl == 0 || h.mode == 2'b00) begin
                popq = 1'b1;
                if (h.mode == 2'b00) m_err = 1'b1;
            end else if (h.store ? (ld0 == 0 && st0 < MAXO) : (st0 == 0 && ld0 < MAXO)) begin
                m_pres = 1'b1;
            end
        end
        if (popq) void'(mq.pop_front());
        if (op_vld && qs0 < DEPTH) begin
            n.store = op_store; n.mode = op_mode; n.sew = op_sew; n.lmul = op_lmul;
            n.dw = op_dw; n.base = op_base; n.stride = op_stride; n.vl = op_vl;
            mq.push_back(n);
        end
        m_ld = ld0 + inc_l - dec_l;
        m_st = st0 + inc_s - dec_s;
    endtask

    // Every output against the model
    task automatic compare_all();
        mem_op_t h;
        h = '0;
        if (m_pres) h = mq[0];
        chk("op_rdy",   op_rdy_o,            mq.size() < DEPTH);
        chk("ld_vld",   mcu_ld_vld_o,        m_pres && !h.store);
        chk("st_vld",   mcu_st_vld_o,        m_pres && h.store);
        chk("sew",      mcu_sew_o,           h.sew);
        chk("lmul",     mcu_lmul_o,          h.lmul);
        chk("dw",       mcu_data_width_o,    h.dw);
        chk("base",     mcu_base_addr_o,     h.base);
        chk("stride",   mcu_stride_o,        h.stride);
        chk("vl",       mcu_vl_o,            h.vl);
        chk("unit",     mcu_unit_ld_st_o,    m_pres && h.mode == 2'b01);
        chk("strided",  mcu_strided_ld_st_o, m_pres && h.mode == 2'b10);
        chk("idx",      mcu_idx_ld_st_o,     m_pres && h.mode == 2'b11);
        chk("ld_out",   ld_out_o,            m_ld);
        chk("st_out",   st_out_o,            m_st);
        chk("busy",     busy_o,              mq.size() > 0 || m_ld > 0 || m_st > 0);
        chk("err",      err_o,               m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_op(input bit st, input logic [1:0] md, input logic [2:0] sew,
                          input logic [31:0] base, input logic [31:0] stride,
                          input logic [31:0] vl);
        op_store = st; op_mode = md; op_sew = sew; op_lmul = 3'b001;
        op_dw = sew; op_base = base; op_stride = stride; op_vl = vl;
    endtask

    // Let everything issue and complete; done pulses follow the model counts
    task automatic drain();
        int n;
        n = 0;
        ld_rdy = 1'b1; st_rdy = 1'b1;
        while ((mq.size() > 0 || m_ld > 0 || m_st > 0) && n < 200) begin
            ld_done = (m_ld > 0);
            st_done = (m_st > 0);
            cycle();
            n++;
        end
        ld_done = 1'b0; st_done = 1'b0; ld_rdy = 1'b0; st_rdy = 1'b0;
        chk("drain_bound", (n < 200), 1);
        chk("drain_busy", busy_o, 0);
    endtask

    // Entered just after a falling edge; reset lands mid-cycle
    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_ld_vld", mcu_ld_vld_o, 0);
        chk("rst_st_vld", mcu_st_vld_o, 0);
        chk("rst_ld_out", ld_out_o, 0);
        chk("rst_st_out", st_out_o, 0);
        chk("rst_busy",   busy_o, 0);
        chk("rst_err",    err_o, 0);
        chk("rst_op_rdy", op_rdy_o, 1);
        compare_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Single unit-stride load
        set_op(1'b0, 2'b01, 3'b010, 32'h4000_0000, 32'h0, 32'd256);
        op_vld = 1'b1;
        cycle();
        op_vld = 1'b0;
        chk("t1_no_vld_at_push", mcu_ld_vld_o, 0);
        cycle();
        chk("t1_ld_vld", mcu_ld_vld_o, 1);
        chk("t1_unit", mcu_unit_ld_st_o, 1);
        chk("t1_base", mcu_base_addr_o, 32'h4000_0000);
        chk("t1_vl", mcu_vl_o, 32'd256);
        chk("t1_sew", mcu_sew_o, 3'b010);
        ld_rdy = 1'b1;
        cycle();
        ld_rdy = 1'b0;
        chk("t1_ld_out_issued", ld_out_o, 1);
        chk("t1_vld_dropped", mcu_ld_vld_o, 0);
        cycle();
        ld_done = 1'b1;
        cycle();
        ld_done = 1'b0;
        chk("t1_ld_out_done", ld_out_o, 0);
        chk("t1_idle", busy_o, 0);

        // Three stores back to back, rdy tied high
        st_rdy = 1'b1;
        set_op(1'b1, 2'b01, 3'b000, 32'h100, 32'h0, 32'd16);
        op_vld = 1'b1;
        cycle();
        set_op(1'b1, 2'b01, 3'b000, 32'h200, 32'h0, 32'd16);
        cycle();
        chk("t2_s1_vld", mcu_st_vld_o, 1);
        chk("t2_s1_base", mcu_base_addr_o, 32'h100);
        set_op(1'b1, 2'b01, 3'b000, 32'h300, 32'h0, 32'd16);
        cycle();
        op_vld = 1'b0;
        chk("t2_gap1", mcu_st_vld_o, 0);
        chk("t2_st_out1", st_out_o, 1);
        cycle();
        chk("t2_s2_vld", mcu_st_vld_o, 1);
        chk("t2_s2_base", mcu_base_addr_o, 32'h200);
        cycle();
        chk("t2_st_out2", st_out_o, 2);
        cycle();
        cycle();
        chk("t2_s3_blocked", mcu_st_vld_o, 0);
        chk("t2_blocked_busy", busy_o, 1);
        st_done = 1'b1;
        cycle();
        st_done = 1'b0;
        chk("t2_after_done_cnt", st_out_o, 1);
        chk("t2_after_done_vld", mcu_st_vld_o, 0);
        cycle();
        chk("t2_s3_vld", mcu_st_vld_o, 1);
        chk("t2_s3_base", mcu_base_addr_o, 32'h300);
        cycle();
        chk("t2_st_out_final", st_out_o, 2);
        drain();

        // Load then strided store: store waits for the load to drain
        ld_rdy = 1'b1; st_rdy = 1'b1;
        set_op(1'b0, 2'b01, 3'b010, 32'h1000, 32'h0, 32'd8);
        op_vld = 1'b1;
        cycle();
        set_op(1'b1, 2'b10, 3'b010, 32'h2000, 32'd8, 32'd8);
        cycle();
        op_vld = 1'b0;
        cycle();
        cycle();
        cycle();
        chk("t3_blocked_vld", mcu_st_vld_o, 0);
        chk("t3_blocked_st_out", st_out_o, 0);
        chk("t3_ld_out", ld_out_o, 1);
        ld_done = 1'b1;
        cycle();
        ld_done = 1'b0;
        chk("t3_done_edge_vld", mcu_st_vld_o, 0);
        chk("t3_ld_drained", ld_out_o, 0);
        cycle();
        chk("t3_st_vld", mcu_st_vld_o, 1);
        chk("t3_stride", mcu_stride_o, 32'd8);
        chk("t3_strided", mcu_strided_ld_st_o, 1);
        chk("t3_not_unit", mcu_unit_ld_st_o, 0);
        drain();

        // Queue full with rdy held low
        ld_rdy = 1'b0; st_rdy = 1'b0;
        op_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(1'b0, 2'b11, 3'b001, 32'h5000 + 32'(i) * 32'h10, 32'h0, 32'd4);
            cycle();
        end
        chk("t4_full", op_rdy_o, 0);
        set_op(1'b0, 2'b01, 3'b001, 32'h5040, 32'h0, 32'd4);
        cycle();
        cycle();
        chk("t4_held", op_rdy_o, 0);
        chk("t4_idx_head", mcu_idx_ld_st_o, 1);
        ld_rdy = 1'b1;
        cycle();
        ld_rdy = 1'b0;
        chk("t4_after_hs_rdy", op_rdy_o, 1);
        chk("t4_after_hs_cnt", ld_out_o, 1);
        cycle();
        op_vld = 1'b0;
        chk("t4_fifth_in", op_rdy_o, 0);
        drain();

        // Zero vl and illegal mode: dropped without issue
        chk("t5_err_clear", err_o, 0);
        set_op(1'b0, 2'b01, 3'b010, 32'h6000, 32'h0, 32'd0);
        op_vld = 1'b1;
        cycle();
        set_op(1'b1, 2'b00, 3'b010, 32'h7000, 32'h0, 32'd5);
        cycle();
        op_vld = 1'b0;
        chk("t5_vl0_no_vld", mcu_ld_vld_o, 0);
        chk("t5_err_not_yet", err_o, 0);
        cycle();
        chk("t5_err_set", err_o, 1);
        chk("t5_no_st_vld", mcu_st_vld_o, 0);
        chk("t5_empty", busy_o, 0);
        cycle();

        // Stray done sets err; reset mid-ISSUE clears everything at once
        do_reset();
        ld_done = 1'b1;
        cycle();
        ld_done = 1'b0;
        chk("t6_stray_err", err_o, 1);
        chk("t6_stray_cnt", ld_out_o, 0);
        ld_rdy = 1'b1;
        set_op(1'b0, 2'b01, 3'b010, 32'h8000, 32'h0, 32'd4);
        op_vld = 1'b1;
        cycle();
        op_vld = 1'b0;
        cycle();
        cycle();
        ld_rdy = 1'b0;
        set_op(1'b0, 2'b01, 3'b010, 32'h9000, 32'h0, 32'd4);
        op_vld = 1'b1;
        cycle();
        op_vld = 1'b0;
        cycle();
        chk("t6_issuing", mcu_ld_vld_o, 1);
        chk("t6_outstanding", ld_out_o, 1);
        do_reset();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_op_sched.md
# mem_op_sched

Issue scheduler between the vector-core dispatch stage and `mem_subsys`. Buffers vector load/store instructions in a small in-order queue, drives the `mcu_*` config bus and `mcu_ld_vld`/`mcu_st_vld` handshakes, and tracks outstanding loads and stores. It enforces a conservative memory-ordering rule: no load/store direction change until the opposite direction has fully drained.

## Interface
- `FIFO_DEPTH`, 4: op queue entries; power of two, at least 2.
- `MAX_OUT`, 2: maximum outstanding ops per direction.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `op_vld_i` in 1: dispatch offers an op.
- `op_rdy_o` out 1: queue not full.
- `op_store_i` in 1: 1 = store, 0 = load.
- `op_mode_i` in 2: 01 unit, 10 strided, 11 indexed; 00 is illegal.
- `op_sew_i`, `op_lmul_i`, `op_data_width_i` in 3 each: vtype and element-width fields.
- `op_base_addr_i`, `op_stride_i`, `op_vl_i` in 32 each.
- `mcu_sew_o`, `mcu_lmul_o`, `mcu_data_width_o` out 3 each.
- `mcu_base_addr_o`, `mcu_stride_o`, `mcu_vl_o` out 32 each.
- `mcu_unit_ld_st_o`, `mcu_strided_ld_st_o`, `mcu_idx_ld_st_o` out 1 each: one-hot decode of the mode.
- `mcu_ld_vld_o` out 1 / `mcu_ld_rdy_i` in 1: load config handshake.
- `mcu_st_vld_o` out 1 / `mcu_st_rdy_i` in 1: store config handshake.
- `ld_done_i` in 1: one-cycle pulse, a load finished (last lane beat written).
- `st_done_i` in 1: one-cycle pulse, a store finished (AXI write done).
- `ld_out_o`, `st_out_o` out `$clog2(MAX_OUT+1)`: outstanding counts.
- `busy_o` out 1: queue non-empty or any op outstanding.
- `err_o` out 1: sticky. Set by a done pulse at count 0, or by an illegal mode.

## Operation
- **Push:** an op is pushed when `op_vld_i && op_rdy_o`. `op_rdy_o` is `!full`, computed from the registered count.
- **FSM states:**
  - IDLE: the queue is empty.
  - ISSUE: `mcu_*_vld_o` is asserted for the head op.
  - WAIT_DRAIN: the head op is blocked.
- **Head-load eligibility** requires both `st_out==0` and `ld_out<MAX_OUT`. A head store is eligible symmetrically.
  - Eligible: IDLE or WAIT_DRAIN → ISSUE.
  - Not eligible: → WAIT_DRAIN.
- **ISSUE:** the matching `mcu_*_vld_o` stays high and all config outputs stay stable until `rdy`.
  - On handshake: pop the head, increment the matching counter, and go to IDLE or WAIT_DRAIN (FIFO empty / head not eligible), otherwise re-evaluate the next head.
- **Idle outputs:** outside ISSUE, all `mcu_*` config outputs and vld outputs are 0.
- **`op_vl_i==0`:** the op is popped at the head without issue, in one cycle, and no counter changes.
- **Illegal mode 00:** the op is popped without issue and `err_o` is set.
- **Counters:** each counter incremented on its issue handshake and decremented on its done pulse. Issue and done in the same cycle leaves the count unchanged. A done pulse at count 0 is ignored and sets `err_o`.
- **Simultaneous push and pop** in one cycle is allowed when not full. Occupancy is then unchanged.

## Timing
- **Reset values:** all outputs are 0, except `op_rdy_o=1` after reset.
  - Reset mid-operation discards the queue and the counters. Outstanding ops in `mem_subsys` are the system's responsibility.
- **Issue latency:** an op pushed at edge N into an empty, eligible scheduler presents `mcu_*_vld_o` with its config after edge N+1.
- **Back-to-back same-direction ops:** one idle cycle between handshakes, because vld drops for one cycle after each handshake.
- **Direction change:** vld for the new direction rises one cycle after the edge on which the last opposite-direction done pulse is sampled.
- **Registered outputs:** `busy_o`, `ld_out_o` and `st_out_o` are registered and reflect the edge on which they were updated.

## Structure
- **`mem_sched_pkg`:**
  - `mem_mode_e`: UNIT, STRIDED, IDX.
  - `mem_op_t`: packed struct with store, mode, sew, lmul, dw, base, stride, vl.
  - `sched_state_e`: IDLE, ISSUE, WAIT_DRAIN.
  - the mode-to-one-hot decode function.
- **Sub-module `mem_op_fifo`:** synchronous FIFO of `mem_op_t`, `FIFO_DEPTH` entries, with full/empty flags and a show-ahead head output.

## Test plan
- **Single load:** one unit-stride load (vl=256, sew=010, base 0x40000000). Expect `mcu_ld_vld_o` high after the push edge +1, `mcu_unit_ld_st_o=1`, `ld_out_o=1` after `rdy`, and 0 after `ld_done_i`.
- **Same-direction back-to-back:** three stores with `mcu_st_rdy_i` tied 1 and MAX_OUT=2. Expect two issues one cycle apart. The third waits until `st_done_i`, then issues on the next cycle.
- **Direction-change ordering:** a load followed by a strided store (stride 8). The store stays blocked with `st_out_o=0` until `ld_done_i`, then issues next cycle with `mcu_stride_o=8` and `mcu_strided_ld_st_o=1`.
- **Queue full:** push 5 ops with `rdy` held low. Expect `op_rdy_o=0` after 4 ops, and the 5th held until the first handshake.
- **Zero vl and illegal mode:** one op with vl=0 and one with mode 00. Neither asserts vld. The second sets `err_o` and the queue empties.
- **Error and reset:** a stray `ld_done_i` at count 0 sets `err_o`. Asserting `rstn` low mid-ISSUE clears vld asynchronously, and all counts read 0 afterwards.
